mem_access_ctrl: RTL

- Sequences single-word CPU memory accesses (MAR/MDR side of the SLC-3 datapath) onto the asynchronous SRAM / test-memory pins.
- Sits between the datapath/ISDU and Mem2IO/test_memory.
- Replaces direct ISDU driving of CE/UB/LB/OE/WE with a timed request/done handshake and configurable wait states.

---
 rtl/mem_access_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Sequences one CPU word access at a time onto the asynchronous SRAM pins.
//   A request is accepted only in IDLE. Address, write data and byte enables
//   are latched on acceptance and drive the SRAM pins for the whole access.
//   The controller then holds OE low (read) or WE low (write) for WAIT_CYCLES
//   cycles and reports completion with a one-cycle done pulse.
//
// Parameters
//   WAIT_CYCLES : cycles OE/WE is held low, 1..15 (4-bit wait counter)
//
// Ports
//   Clk, Reset              : clock, synchronous active-high reset
//   req_read, req_write     : access requests, sampled only in IDLE
//   addr, wdata, byte_en    : word address, write data, byte lanes ([1]=upper)
//   rdata                   : data captured from the SRAM on a read
//   busy, done, req_err     : not-idle flag, completion pulse, reject pulse
//   ADDR, Data_out, Data_oe : SRAM address, write data, bus drive enable
//   Data_in                 : SRAM read data
//   CE, UB, LB, OE, WE      : active-low SRAM strobes
module mem_access_ctrl #(
    parameter int unsigned WAIT_CYCLES = 2
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        req_read,
    input  logic        req_write,
    input  logic [19:0] addr,
    input  logic [15:0] wdata,
    input  logic [1:0]  byte_en,
    output logic [15:0] rdata,
    output logic        busy,
    output logic        done,
    output logic        req_err,
    output logic [19:0] ADDR,
    output logic [15:0] Data_out,
    output logic        Data_oe,
    input  logic [15:0] Data_in,
    output logic        CE,
    output logic        UB,
    output logic        LB,
    output logic        OE,
    output logic        WE
);

    typedef enum logic [2:0] {
        IDLE,
        RD_ACC,
        RD_DONE,
        WR_SETUP,
        WR_PULSE,
        WR_HOLD
    } state_t;

    // The counter runs from WAIT_CYCLES-1 down to 0, so the strobe phase
    // lasts exactly WAIT_CYCLES cycles.
    localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_next;
    logic [3:0]  cnt;
    logic [3:0]  cnt_next;
    logic [1:0]  be_q;
    logic        accept;
    logic        reject;
    logic        capture;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= IDLE;
            cnt      <= '0;
            be_q     <= '0;
            rdata    <= '0;
            ADDR     <= '0;
            Data_out <= '0;
            req_err  <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            req_err <= reject;
            if (accept) begin
                ADDR     <= addr;
                Data_out <= wdata;
                be_q     <= byte_en;
            end
            if (capture) begin
                rdata <= Data_in;
            end
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        accept     = 1'b0;
        reject     = 1'b0;
        capture    = 1'b0;
        busy       = 1'b1;
        done       = 1'b0;
        CE         = 1'b1;
        UB         = 1'b1;
        LB         = 1'b1;
        OE         = 1'b1;
        WE         = 1'b1;
        Data_oe    = 1'b0;

        case (state)
            IDLE: begin
                busy = 1'b0;
                if (req_read || req_write) begin
                    // Conflicting requests or no byte lane selected are
                    // rejected without touching the SRAM.
                    if ((req_read && req_write) || (byte_en == 2'b00)) begin
                        reject = 1'b1;
                    end else begin
                        accept     = 1'b1;
                        cnt_next   = CNT_LOAD;
                        state_next = req_read ? RD_ACC : WR_SETUP;
                    end
                end
            end

            RD_ACC: begin
                CE = 1'b0;
                OE = 1'b0;
                UB = ~be_q[1];
                LB = ~be_q[0];
                if (cnt == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RD_DONE;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            RD_DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            WR_SETUP: begin
                CE         = 1'b0;
                UB         = ~be_q[1];
                LB         = ~be_q[0];
                Data_oe    = 1'b1;
                cnt_next   = CNT_LOAD;
                state_next = WR_PULSE;
            end

            WR_PULSE: begin
                CE      = 1'b0;
                UB      = ~be_q[1];
                LB      = ~be_q[0];
                WE      = 1'b0;
                Data_oe = 1'b1;
                if (cnt == 4'd0) begin
                    state_next = WR_HOLD;
                end else begin
                    cnt_next = cnt - 4'd1;
                end
            end

            WR_HOLD: begin
                // WE has risen; keep the chip selected and the bus driven
                // for one cycle so the SRAM sees stable data at the WE edge.
                CE         = 1'b0;
                UB         = ~be_q[1];
                LB         = ~be_q[0];
                Data_oe    = 1'b1;
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
